memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of the execute stage and consumes its EX/MEM register outputs: ALU result/address, store data, width, sign flag and control bits. It performs byte/half/word loads and stores on an internal byte-addressable data memory and drives the MEM/WB pipeline register consumed by write-back. It also exposes a read-only debug port for memory dump.

Parameters:
NB_DATA, 32, datapath width (fixed 32; lane logic assumes 4 bytes)
NB_ADDR, 8, word-index width; memory depth = 2^NB_ADDR words

Ports:
clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_stall  in  1  freeze stage: no store, MEM/WB held
i_halt  in  1  freeze stage, same effect as i_stall
i_alu_result  in  NB_DATA  EX/MEM ALU result; byte address for loads/stores
i_data4Mem  in  NB_DATA  store data (lane 0 aligned)
i_write_reg  in  5  destination register number
i_mem2reg  in  1  write-back selects load data
i_memRead  in  1  load
i_memWrite  in  1  store
i_regWrite  in  1  register-file write enable
i_width  in  2  00 byte, 01 half, 11 word, 10 reserved (treated as word)
i_sign_flag  in  1  1 sign-extend loads, 0 zero-extend
i_dbg_addr  in  NB_ADDR  debug word index
o_dbg_data  out  NB_DATA  memory word at i_dbg_addr, combinational
o_alu_result  out  NB_DATA  MEM/WB ALU result
o_read_data  out  NB_DATA  MEM/WB extended load data
o_write_reg  out  5  MEM/WB destination
o_mem2reg  out  1  MEM/WB mem2reg
o_regWrite  out  1  MEM/WB regWrite
o_misaligned  out  1  MEM/WB: access was misaligned

Behaviour:
- Reset (async, active-low): all MEM/WB outputs 0. Memory contents are not affected by reset.
- Word index = i_alu_result[NB_ADDR+1:2]; lane = i_alu_result[1:0]. Upper address bits are ignored, so addresses wrap modulo 2^(NB_ADDR+2).
- Little-endian: byte lane k = word bits [8k+7:8k]; a half at lane 2 occupies bits [31:16].
- Misaligned when half with lane[0]=1, or word with lane!=00. A misaligned store is suppressed. A misaligned load returns 0. Both set o_misaligned for that instruction's MEM/WB cycle.
- Store:
  - Written at the posedge when i_memWrite=1, aligned, i_stall=0, i_halt=0 and i_rst_n=1.
  - Byte enable: byte -> 1 lane; half -> 2 lanes (lane[1] selects); word -> all 4 lanes.
  - Data is taken from the low bits of i_data4Mem and replicated to the selected lanes.
- Load:
  - Combinational array read. The lane/half is selected, then extended per i_sign_flag (word unaffected), then registered into o_read_data.
  - Latency: 1 clock from EX/MEM inputs to MEM/WB outputs.
  - When i_memRead=0, o_read_data captures 0.
- Simultaneous i_memRead and i_memWrite: store performed; read data is the pre-write word (read-before-write).
- Load immediately after a store to the same word, in the next cycle: sees the new data.
- i_stall or i_halt: all MEM/WB registers hold their value, no store occurs, and o_dbg_data remains live.
- Pass-through: o_alu_result, o_write_reg, o_mem2reg and o_regWrite are registered copies of their inputs.
- o_regWrite is forced to 0 for a misaligned load.
- Reset asserted mid-operation: outputs clear immediately; a store on that edge is not performed.

Decomposition:
- Shared package mips_pkg: width codes (W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b11) and NB_DATA default.
- Sub-module data_memory: byte-enable, synchronous-write, asynchronous dual-read RAM. It has a pipeline read port and a debug read port, with parameters NB_DATA and NB_ADDR.
- Lane select/extend logic and the MEM/WB register stay in memory_access_stage.

Test Plan:
- Word store/load: store 0xDEADBEEF at addr 0x10, then load word at 0x10 -> o_read_data=0xDEADBEEF one clock later; o_dbg_data at index 4 = 0xDEADBEEF.
- Byte sign/zero extension: after the word store, load byte at 0x13 with sign=1 -> 0xFFFFFFDE; with sign=0 -> 0x000000DE. Load half at 0x10 with sign=1 -> 0xFFFFBEEF.
- Partial stores: store byte 0x55 at 0x11 -> word 0xDEAD55EF. Store half 0x1234 at 0x12 -> word 0x123455EF.
- Misaligned: word store at 0x21 -> memory unchanged, o_misaligned=1. Half load at 0x11 -> o_read_data=0, o_regWrite=0, o_misaligned=1.
- Stall/halt: assert i_stall with a store pending -> no write and MEM/WB outputs held. Deassert -> store completes on the next edge.
- Reset: async reset mid-stream -> all outputs 0 without a clock edge. Memory retains 0x123455EF at 0x10.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared width codes and datapath defaults for the MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int MIPS_NB_DATA = 32;

    // Access width codes; 2'b10 is reserved and handled as a word access.
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Brief    : Byte-enable RAM, synchronous write, asynchronous pipeline and
//            debug read ports. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory
    import mips_pkg::*;
#(
    parameter int NB_DATA = MIPS_NB_DATA,
    parameter int NB_ADDR = 8
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [NB_DATA/8-1:0] i_be,
    input  logic [NB_ADDR-1:0]   i_addr,
    input  logic [NB_DATA-1:0]   i_wdata,
    output logic [NB_DATA-1:0]   o_rdata,
    input  logic [NB_ADDR-1:0]   i_dbg_addr,
    output logic [NB_DATA-1:0]   o_dbg_data
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int DEPTH    = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < NB_BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reads return the pre-write word on the write cycle.
    assign o_rdata    = r_mem[i_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule : data_memory
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_stage
// Brief    : MIPS MEM stage - byte/half/word loads and stores on the data
//            memory, feeding the MEM/WB pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module memory_access_stage
    import mips_pkg::*;
#(
    parameter int NB_DATA = MIPS_NB_DATA,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [4:0]         i_write_reg,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [4:0]         o_write_reg,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic               o_misaligned
);

    logic [NB_ADDR-1:0] w_word_idx;
    logic [1:0]         w_lane;
    logic               w_is_byte;
    logic               w_is_half;
    logic               w_is_word;
    logic               w_misaligned;
    logic               w_access;
    logic               w_freeze;
    logic               w_we;
    logic [3:0]         w_be;
    logic [NB_DATA-1:0] w_wdata;
    logic [NB_DATA-1:0] w_rword;
    logic [7:0]         w_rbyte;
    logic [15:0]        w_rhalf;
    logic [NB_DATA-1:0] w_load_ext;
    logic [NB_DATA-1:0] w_load_data;

    assign w_word_idx = i_alu_result[NB_ADDR+1:2];
    assign w_lane     = i_alu_result[1:0];
    assign w_is_byte  = (i_width == W_BYTE);
    assign w_is_half  = (i_width == W_HALF);
    assign w_is_word  = !w_is_byte && !w_is_half;
    assign w_access   = i_memRead || i_memWrite;
    assign w_misaligned = w_access &&
                          ((w_is_half && w_lane[0]) || (w_is_word && (w_lane != 2'b00)));
    assign w_freeze   = i_stall || i_halt;

    // Reset gating keeps a store from landing on the edge reset is asserted.
    assign w_we = i_memWrite && !w_misaligned && !w_freeze && i_rst_n;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_data4Mem;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_data4Mem[7:0]}};
        end else if (w_is_half) begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_data4Mem[15:0]}};
        end
    end

    data_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_data_memory (
        .clk        (clk),
        .i_we       (w_we),
        .i_be       (w_be),
        .i_addr     (w_word_idx),
        .i_wdata    (w_wdata),
        .o_rdata    (w_rword),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];
    assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load_ext = w_rword;
        if (w_is_byte) begin
            w_load_ext = {{24{i_sign_flag && w_rbyte[7]}}, w_rbyte};
        end else if (w_is_half) begin
            w_load_ext = {{16{i_sign_flag && w_rhalf[15]}}, w_rhalf};
        end
    end

    assign w_load_data = (i_memRead && !w_misaligned) ? w_load_ext : '0;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_result <= '0;
            o_read_data  <= '0;
            o_write_reg  <= '0;
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (!w_freeze) begin
            o_alu_result <= i_alu_result;
            o_read_data  <= w_load_data;
            o_write_reg  <= i_write_reg;
            o_mem2reg    <= i_mem2reg;
            o_regWrite   <= i_regWrite && !(i_memRead && w_misaligned);
            o_misaligned <= w_misaligned;
        end
    end

endmodule : memory_access_stage
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_stage
// Brief    : Directed vector bench for memory_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;
    import mips_pkg::*;

    logic        clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_halt;
    logic [31:0] i_alu_result;
    logic [31:0] i_data4Mem;
    logic [4:0]  i_write_reg;
    logic        i_mem2reg;
    logic        i_memRead;
    logic        i_memWrite;
    logic        i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic [7:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;
    logic [31:0] o_alu_result;
    logic [31:0] o_read_data;
    logic [4:0]  o_write_reg;
    logic        o_mem2reg;
    logic        o_regWrite;
    logic        o_misaligned;

    memory_access_stage #(
        .NB_DATA (32),
        .NB_ADDR (8)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_halt       (i_halt),
        .i_alu_result (i_alu_result),
        .i_data4Mem   (i_data4Mem),
        .i_write_reg  (i_write_reg),
        .i_mem2reg    (i_mem2reg),
        .i_memRead    (i_memRead),
        .i_memWrite   (i_memWrite),
        .i_regWrite   (i_regWrite),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_data   (o_dbg_data),
        .o_alu_result (o_alu_result),
        .o_read_data  (o_read_data),
        .o_write_reg  (o_write_reg),
        .o_mem2reg    (o_mem2reg),
        .o_regWrite   (o_regWrite),
        .o_misaligned (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic        sign;
        logic        regw;
        logic [4:0]  wreg;
        logic [7:0]  dbg_idx;
        logic [31:0] exp_rd;
        logic        exp_regw;
        logic        exp_mis;
        logic [31:0] exp_dbg;
    } vec_t;

    localparam int N_VEC = 18;
    vec_t vecs [N_VEC];

    int n_total = 0;
    int n_pass  = 0;

    function automatic vec_t mk(input logic [1:0] width, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rd, input logic wr,
                                input logic sign, input logic regw, input logic [4:0] wreg,
                                input logic [7:0] dbg_idx, input logic [31:0] exp_rd,
                                input logic exp_regw, input logic exp_mis,
                                input logic [31:0] exp_dbg);
        vec_t v;
        v.width = width;   v.addr = addr;         v.wdata = wdata;
        v.rd = rd;         v.wr = wr;             v.sign = sign;
        v.regw = regw;     v.wreg = wreg;         v.dbg_idx = dbg_idx;
        v.exp_rd = exp_rd; v.exp_regw = exp_regw; v.exp_mis = exp_mis;
        v.exp_dbg = exp_dbg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_width      = v.width;
        i_alu_result = v.addr;
        i_data4Mem   = v.wdata;
        i_memRead    = v.rd;
        i_mem2reg    = v.rd;
        i_memWrite   = v.wr;
        i_sign_flag  = v.sign;
        i_regWrite   = v.regw;
        i_write_reg  = v.wreg;
        i_dbg_addr   = v.dbg_idx;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_alu"},  o_alu_result, 32'h0);
        check({tag, "_rd"},   o_read_data, 32'h0);
        check({tag, "_wreg"}, {27'h0, o_write_reg}, 32'h0);
        check({tag, "_m2r"},  {31'h0, o_mem2reg}, 32'h0);
        check({tag, "_regw"}, {31'h0, o_regWrite}, 32'h0);
        check({tag, "_mis"},  {31'h0, o_misaligned}, 32'h0);
    endtask

    initial begin
        //           width   addr         wdata        rd   wr   sg   rw   wreg  dbg    exp_rd       erw  emis exp_dbg
        vecs[0]  = mk(W_WORD, 32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd4, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF);
        vecs[1]  = mk(W_WORD, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 8'd4, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF);
        vecs[2]  = mk(W_BYTE, 32'h13,  32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 8'd4, 32'hFFFFFFDE, 1'b1, 1'b0, 32'hDEADBEEF);
        vecs[3]  = mk(W_BYTE, 32'h13,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 8'd4, 32'h000000DE, 1'b1, 1'b0, 32'hDEADBEEF);
        vecs[4]  = mk(W_HALF, 32'h10,  32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 8'd4, 32'hFFFFBEEF, 1'b1, 1'b0, 32'hDEADBEEF);
        vecs[5]  = mk(W_HALF, 32'h12,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 8'd4, 32'h0000DEAD, 1'b1, 1'b0, 32'hDEADBEEF);
        vecs[6]  = mk(W_BYTE, 32'h11,  32'h00000055, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 8'd4, 32'h0,        1'b0, 1'b0, 32'hDEAD55EF);
        vecs[7]  = mk(W_HALF, 32'h12,  32'h00001234, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 8'd4, 32'h0,        1'b0, 1'b0, 32'h123455EF);
        vecs[8]  = mk(W_WORD, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 8'd4, 32'h123455EF, 1'b1, 1'b0, 32'h123455EF);
        vecs[9]  = mk(W_WORD, 32'h20,  32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 8'd8, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D);
        vecs[10] = mk(W_WORD, 32'h21,  32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 8'd8, 32'h0,       1'b0, 1'b1, 32'hCAFEF00D);
        vecs[11] = mk(W_HALF, 32'h11,  32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 8'd4, 32'h0,       1'b0, 1'b1, 32'h123455EF);
        vecs[12] = mk(W_BYTE, 32'h21,  32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 8'd8, 32'hFFFFFFF0, 1'b1, 1'b0, 32'hCAFEF00D);
        vecs[13] = mk(W_WORD, 32'h20,  32'h01020304, 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 8'd8, 32'hCAFEF00D, 1'b1, 1'b0, 32'h01020304);
        vecs[14] = mk(W_WORD, 32'h20,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 8'd8, 32'h01020304, 1'b1, 1'b0, 32'h01020304);
        vecs[15] = mk(W_WORD, 32'h420, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 8'd8, 32'h01020304, 1'b1, 1'b0, 32'h01020304);
        vecs[16] = mk(W_HALF, 32'h22,  32'hFFFFABCD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, 8'd8, 32'h0,        1'b0, 1'b0, 32'hABCD0304);
        vecs[17] = mk(2'b10,  32'h23,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd17, 8'd8, 32'h0,        1'b0, 1'b1, 32'hABCD0304);

        i_rst_n = 1'b0;
        i_stall = 1'b0;
        i_halt  = 1'b0;
        drive(mk(W_WORD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0,
                 32'h0, 1'b0, 1'b0, 32'h0));
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rd", i),   o_read_data, vecs[i].exp_rd);
            check($sformatf("v%0d_regw", i), {31'h0, o_regWrite}, {31'h0, vecs[i].exp_regw});
            check($sformatf("v%0d_mis", i),  {31'h0, o_misaligned}, {31'h0, vecs[i].exp_mis});
            check($sformatf("v%0d_alu", i),  o_alu_result, vecs[i].addr);
            check($sformatf("v%0d_wreg", i), {27'h0, o_write_reg}, {27'h0, vecs[i].wreg});
            check($sformatf("v%0d_m2r", i),  {31'h0, o_mem2reg}, {31'h0, vecs[i].rd});
            check($sformatf("v%0d_dbg", i),  o_dbg_data, vecs[i].exp_dbg);
        end

        // Reserved-width byte load at lane 3 is misaligned; reload as a byte to prime held state.
        drive(mk(W_BYTE, 32'h23, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd18, 8'd8,
                 32'h0, 1'b0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        check("byte23_rd", o_read_data, 32'h000000AB);

        // Stall then halt with a store pending: nothing moves.
        drive(mk(W_WORD, 32'h20, 32'h77777777, 1'b0, 1'b1, 1'b0, 1'b1, 5'd19, 8'd8,
                 32'h0, 1'b0, 1'b0, 32'h0));
        i_stall = 1'b1;
        @(posedge clk);
        #1;
        check("stall_dbg",  o_dbg_data, 32'hABCD0304);
        check("stall_rd",   o_read_data, 32'h000000AB);
        check("stall_alu",  o_alu_result, 32'h23);
        check("stall_wreg", {27'h0, o_write_reg}, 32'd18);
        i_stall = 1'b0;
        i_halt  = 1'b1;
        @(posedge clk);
        #1;
        check("halt_dbg",  o_dbg_data, 32'hABCD0304);
        check("halt_rd",   o_read_data, 32'h000000AB);
        check("halt_alu",  o_alu_result, 32'h23);
        i_halt = 1'b0;
        @(posedge clk);
        #1;
        check("release_dbg",  o_dbg_data, 32'h77777777);
        check("release_alu",  o_alu_result, 32'h20);
        check("release_rd",   o_read_data, 32'h0);
        check("release_wreg", {27'h0, o_write_reg}, 32'd19);

        // Async reset mid-cycle with a store pending on the following edge.
        drive(mk(W_WORD, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 8'd4,
                 32'h0, 1'b0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        check("pre_rst_rd", o_read_data, 32'h123455EF);
        drive(mk(W_WORD, 32'h10, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd21, 8'd4,
                 32'h0, 1'b0, 1'b0, 32'h0));
        #2;
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(posedge clk);
        #1;
        check("rst_edge_dbg", o_dbg_data, 32'h123455EF);
        i_memWrite = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_dbg", o_dbg_data, 32'h123455EF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_memory_access_stage
`default_nettype wire
